// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg
// Shared definitions for the tick_timer block: register addresses, the bit
// positions inside CTRL and STATUS, the FSM state type and a small helper
// for the saturating overrun counter.
// Optional feature macro used by the block: TICK_TIMER_OVERRUN_EN.

package tick_timer_pkg;

  // Register map (2-bit register select)
  localparam logic [1:0] TT_CTRL   = 2'd0;
  localparam logic [1:0] TT_LOAD   = 2'd1;
  localparam logic [1:0] TT_COUNT  = 2'd2;
  localparam logic [1:0] TT_STATUS = 2'd3;

  // CTRL bit positions
  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;
  localparam int CTRL_WIDTH        = 3;

  // STATUS bit positions
  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_OVERRUN_BIT = 1;
  localparam int OVERRUN_CNT_LSB    = 8;
  localparam int OVERRUN_CNT_MSB    = 15;

  // Countdown FSM states. IDLE and DONE both ignore tick; DONE is only
  // reached by a one-shot expiry, IDLE by reset or an explicit disable.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tt_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/tick_timer_core.sv
// tick_timer_core
// Holds the COUNT register and the IDLE/RUN/DONE countdown FSM.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   tick            one-cycle strobe; decrements COUNT while running
//   ctrl_wr         CTRL register written this cycle
//   ctrl_enable     enable bit of the CTRL write data
//   periodic        current (registered) CTRL.periodic
//   count_wr        COUNT register written this cycle
//   count_data      value written to COUNT
//   load_value      current (registered) LOAD value
//   count           current COUNT
//   expire          one-cycle strobe, high in the cycle an expiring tick
//                   is accepted (combinational, consumed by the top level)

module tick_timer_core
  import tick_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             ctrl_wr,
  input  logic             ctrl_enable,
  input  logic             periodic,
  input  logic             count_wr,
  input  logic [WIDTH-1:0] count_data,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             expire
);

  tt_state_e        state;
  tt_state_e        state_next;
  logic [WIDTH-1:0] count_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Priority: disable > (re)enable from IDLE/DONE > COUNT write > tick.
  // A CTRL write with enable=1 while already running does not restart the
  // count, so software can change irq_en/periodic without losing progress.
  always_comb begin
    state_next = state;
    count_next = count;
    expire     = 1'b0;
    if (ctrl_wr && !ctrl_enable) begin
      state_next = IDLE;
    end else if (ctrl_wr && (state != RUN)) begin
      count_next = load_value;
      state_next = RUN;
    end else if (count_wr) begin
      count_next = count_data;
    end else if ((state == RUN) && tick) begin
      if (count == '0) begin
        expire = 1'b1;
        if (periodic) begin
          count_next = load_value;
        end else begin
          state_next = DONE;
        end
      end else begin
        count_next = count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/tick_timer.sv
// tick_timer
// Programmable countdown timer clocked by an upstream tick strobe, with a
// software register interface and a level interrupt held until acknowledged.
//
// Parameters:
//   WIDTH   counter / LOAD width (at least 16)
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   tick        one-cycle strobe from the pulse generator
//   wr_en       register write strobe
//   wr_addr     write register select (CTRL, LOAD, COUNT, STATUS)
//   wr_data     write data
//   rd_addr     read register select
//   rd_data     combinational read of the selected register
//   ack         one-cycle interrupt acknowledge, clears pending
//   irq         registered pending & CTRL.irq_en
// Optional feature macro: TICK_TIMER_OVERRUN_EN adds a sticky overrun flag
// (STATUS bit1) and a saturating overrun counter (STATUS[15:8]).

module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             ack,
  output logic             irq
);

  logic [CTRL_WIDTH-1:0] ctrl_q;
  logic [CTRL_WIDTH-1:0] ctrl_d;
  logic [WIDTH-1:0]      load_q;
  logic                  pending_q;
  logic                  pending_d;
  logic                  irq_q;
  logic [WIDTH-1:0]      count;
  logic                  expire;

  logic ctrl_wr;
  logic load_wr;
  logic count_wr;
  logic status_wr;

  assign ctrl_wr   = wr_en && (wr_addr == TT_CTRL);
  assign load_wr   = wr_en && (wr_addr == TT_LOAD);
  assign count_wr  = wr_en && (wr_addr == TT_COUNT);
  assign status_wr = wr_en && (wr_addr == TT_STATUS);

  tick_timer_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .ctrl_wr    (ctrl_wr),
    .ctrl_enable(wr_data[CTRL_ENABLE_BIT]),
    .periodic   (ctrl_q[CTRL_PERIODIC_BIT]),
    .count_wr   (count_wr),
    .count_data (wr_data),
    .load_value (load_q),
    .count      (count),
    .expire     (expire)
  );

  // Next CTRL and pending values. The irq flop is fed from these so that
  // irq moves on the same edge as pending/CTRL rather than a cycle later.
  // An expiry always beats a simultaneous ack or write-1-clear.
  always_comb begin
    ctrl_d    = ctrl_wr ? wr_data[CTRL_WIDTH-1:0] : ctrl_q;
    pending_d = pending_q;
    if (expire) begin
      pending_d = 1'b1;
    end else if (ack || (status_wr && wr_data[STATUS_PENDING_BIT])) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      irq_q     <= pending_d & ctrl_d[CTRL_IRQ_EN_BIT];
      if (load_wr) begin
        load_q <= wr_data;
      end
    end
  end

  assign irq = irq_q;

`ifdef TICK_TIMER_OVERRUN_EN
  logic       overrun_q;
  logic [7:0] overrun_cnt_q;
  logic       overrun_hit;
  logic       overrun_clr;

  assign overrun_hit = expire && pending_q;
  assign overrun_clr = status_wr && wr_data[STATUS_OVERRUN_BIT];

  // A new overrun in the same cycle as a clear restarts the count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
    end else if (overrun_hit) begin
      overrun_q     <= 1'b1;
      overrun_cnt_q <= overrun_clr ? 8'd1 : sat_inc8(overrun_cnt_q);
    end else if (overrun_clr) begin
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
    end
  end
`endif

  // Read mux; unused bits of CTRL and STATUS read as zero.
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      TT_CTRL:   rd_data[CTRL_WIDTH-1:0] = ctrl_q;
      TT_LOAD:   rd_data = load_q;
      TT_COUNT:  rd_data = count;
      TT_STATUS: begin
        rd_data[STATUS_PENDING_BIT] = pending_q;
`ifdef TICK_TIMER_OVERRUN_EN
        rd_data[STATUS_OVERRUN_BIT] = overrun_q;
        rd_data[OVERRUN_CNT_MSB:OVERRUN_CNT_LSB] = overrun_cnt_q;
`endif
      end
      default:   rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer
// Scoreboard bench for tick_timer. A driver applies one set of inputs per
// cycle, advances a behavioural model of the timer and queues the expected
// irq and rd_data for after the edge; a monitor pops and compares them.

module tb_tick_timer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tick;
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [1:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             ack;
  logic             irq;

  always #5 clk = ~clk;

  tick_timer #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .ack    (ack),
    .irq    (irq)
  );

  typedef struct {
    logic             irq;
    logic [1:0]       addr;
    logic [WIDTH-1:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: IDLE and DONE are indistinguishable from outside,
  // so only "running or not" is tracked.
  logic [2:0]       m_ctrl;
  logic [WIDTH-1:0] m_load;
  logic [WIDTH-1:0] m_count;
  bit               m_running;
  bit               m_pending;
  bit               m_ovf;
  int               m_ovf_cnt;

  task automatic model_reset();
    m_ctrl    = '0;
    m_load    = '0;
    m_count   = '0;
    m_running = 0;
    m_pending = 0;
    m_ovf     = 0;
    m_ovf_cnt = 0;
  endtask

  function automatic logic [WIDTH-1:0] model_read(input logic [1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    case (a)
      2'd0: v[2:0] = m_ctrl;
      2'd1: v = m_load;
      2'd2: v = m_count;
      default: begin
        v[0] = m_pending;
`ifdef TICK_TIMER_OVERRUN_EN
        v[1]    = m_ovf;
        v[15:8] = m_ovf_cnt[7:0];
`endif
      end
    endcase
    return v;
  endfunction

  task automatic model_step(input bit t, input bit w, input logic [1:0] a,
                            input logic [WIDTH-1:0] d, input bit k);
    bit expire;
    bit do_tick;
    bit was_periodic;
    bit was_pending;
    expire       = 0;
    was_periodic = m_ctrl[1];
    was_pending  = m_pending;
    do_tick      = m_running && t;
    if (w && a == 2'd0 && !d[0]) begin
      m_running = 0;
      do_tick   = 0;
    end else if (w && a == 2'd0 && !m_running) begin
      m_count   = m_load;
      m_running = 1;
      do_tick   = 0;
    end else if (w && a == 2'd2) begin
      m_count = d;
      do_tick = 0;
    end
    if (do_tick) begin
      if (m_count == 0) begin
        expire = 1;
        if (was_periodic) m_count = m_load;
        else m_running = 0;
      end else begin
        m_count = m_count - 1;
      end
    end
    if (w && a == 2'd0) m_ctrl = d[2:0];
    if (w && a == 2'd1) m_load = d;
`ifdef TICK_TIMER_OVERRUN_EN
    if (expire && was_pending) begin
      m_ovf = 1;
      if (w && a == 2'd3 && d[1]) m_ovf_cnt = 1;
      else if (m_ovf_cnt < 255) m_ovf_cnt++;
    end else if (w && a == 2'd3 && d[1]) begin
      m_ovf     = 0;
      m_ovf_cnt = 0;
    end
`endif
    if (expire) m_pending = 1;
    else if (k || (w && a == 2'd3 && d[0])) m_pending = 0;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, advance the model,
  // queue the post-edge expectation and move to the next negedge.
  task automatic applyStimulus(input bit t, input bit w, input logic [1:0] a,
                               input logic [WIDTH-1:0] d, input bit k,
                               input logic [1:0] ra);
    exp_t e;
    tick    = t;
    wr_en   = w;
    wr_addr = a;
    wr_data = d;
    ack     = k;
    rd_addr = ra;
    model_step(t, w, a, d, k);
    e.irq  = m_pending & m_ctrl[2];
    e.addr = ra;
    e.rd   = model_read(ra);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [1:0] ra);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 2'd0, '0, 0, ra);
  endtask

  task automatic wr(input logic [1:0] a, input logic [WIDTH-1:0] d);
    applyStimulus(0, 1, a, d, 0, a);
  endtask

  // Asynchronous reset pulse, checked immediately while rst_n is low.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      if (a == 0) checkOutput("irq_in_reset", {31'd0, irq}, '0);
      checkOutput($sformatf("reset_reg%0d", a), rd_data, '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare one queued expectation after every active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("irq", {31'd0, irq}, {31'd0, e.irq});
        checkOutput($sformatf("rd_data[%0d]", e.addr), rd_data, e.rd);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, queue=%0d", exp_q.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    tick = 0; wr_en = 0; wr_addr = '0; wr_data = '0; ack = 0; rd_addr = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // One-shot: LOAD=3, enable with irq_en, four ticks then extra ticks.
    wr(2'd1, 3);
    wr(2'd0, 5);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 2'd0, '0, 0, 2'd2);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 2'd0, '0, 0, 2'd2);
    applyStimulus(0, 0, 2'd0, '0, 1, 2'd3);
    idle(1, 2'd3);

    // Periodic: LOAD=2, ack after each expiry.
    wr(2'd0, 0);
    wr(2'd1, 2);
    wr(2'd0, 7);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 0, 2'd0, '0, 0, 2'd2);
      if (m_pending) applyStimulus(0, 0, 2'd0, '0, 1, 2'd3);
    end

    // Expire coincides with ack: pending must survive, later ack clears.
    guard = 0;
    while (m_count != 0 && guard < 10) begin
      applyStimulus(1, 0, 2'd0, '0, 0, 2'd2);
      guard++;
    end
    applyStimulus(1, 0, 2'd0, '0, 1, 2'd3);
    applyStimulus(0, 0, 2'd0, '0, 1, 2'd3);

    // COUNT write coincident with tick; disable coincident with expiry.
    applyStimulus(1, 1, 2'd2, 5, 0, 2'd2);
    wr(2'd2, 0);
    applyStimulus(1, 1, 2'd0, 6, 0, 2'd3);
    applyStimulus(1, 0, 2'd0, '0, 0, 2'd2);

    // Reset mid-run, then ticks must be ignored.
    wr(2'd1, 100);
    wr(2'd0, 5);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 2'd0, '0, 0, 2'd2);
    do_reset();
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 2'd0, '0, 0, 2'd2);

`ifdef TICK_TIMER_OVERRUN_EN
    // Overrun saturation and clear.
    wr(2'd1, 0);
    wr(2'd0, 3);
    for (int i = 0; i < 300; i++) applyStimulus(1, 0, 2'd0, '0, 0, 2'd3);
    wr(2'd0, 0);
    wr(2'd3, 2);
    idle(1, 2'd3);
`endif

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      bit               t;
      bit               w;
      bit               k;
      logic [1:0]       a;
      logic [WIDTH-1:0] d;
      t = ($urandom_range(0, 1) == 1);
      w = ($urandom_range(0, 7) == 0);
      k = ($urandom_range(0, 9) == 0);
      a = 2'($urandom_range(0, 3));
      case (a)
        2'd0:    d = WIDTH'($urandom_range(0, 7) | ($urandom_range(0, 3) != 0 ? 1 : 0));
        2'd1:    d = WIDTH'($urandom_range(0, 7));
        2'd2:    d = WIDTH'($urandom_range(0, 9));
        default: d = WIDTH'($urandom_range(0, 3));
      endcase
      applyStimulus(t, w, a, d, k, 2'($urandom_range(0, 3)));
      if (i % 1000 == 999) do_reset();
    end

    idle(2, 2'd3);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
